// File: rtl/dcache_direct_wb.sv
// dcache_direct_wb: direct-mapped, write-back, write-allocate data cache.
// Geometry: 8 lines x 4 bytes, 8-bit byte address {tag[7:5], index[4:2], offset[1:0]}.
// A miss latches the block address, writes back a dirty victim if needed,
// then fetches the requested block; the held CPU request hits afterwards.
// Optional build macro DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache_direct_wb (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH
    } state_t;

    state_t state, next_state;

    logic [31:0] data_arr [8];
    logic [2:0]  tag_arr  [8];
    logic [7:0]  valid_arr;
    logic [7:0]  dirty_arr;

    logic [5:0]  miss_blk;    // {tag,index} of the block being refilled
    logic [7:0]  readdata_q;  // last byte returned, held between read hits

    logic [2:0]  index;
    logic [1:0]  offset;
    logic [2:0]  miss_index;
    logic        req;
    logic        hit;
    logic        read_hit;
    logic        write_hit;
    logic        miss_start;
    logic        mem_done;
    logic [7:0]  sel_byte;

    assign index      = address[4:2];
    assign offset     = address[1:0];
    assign miss_index = miss_blk[2:0];
    assign req        = read | write;
    assign hit        = valid_arr[index] && (tag_arr[index] == address[7:5]);
    // A simultaneous read and write is a store.
    assign read_hit   = (state == IDLE) && read && !write && hit;
    assign write_hit  = (state == IDLE) && write && hit;
    assign miss_start = (state == IDLE) && req && !hit;
    assign mem_done   = !mem_busywait;
    assign sel_byte   = data_arr[index][{offset, 3'b000} +: 8];
    assign readdata   = read_hit ? sel_byte : readdata_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and memory-handshake outputs.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        next_state    = state;
        busywait      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = miss_blk;
        mem_writedata = data_arr[miss_index];
        case (state)
            IDLE: begin
                if (miss_start) begin
                    busywait   = 1'b1;
                    next_state = (valid_arr[index] && dirty_arr[index]) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                busywait    = 1'b1;
                mem_write   = 1'b1;
                mem_address = {tag_arr[miss_index], miss_index};
                if (mem_done) next_state = FETCH;
            end
            FETCH: begin
                busywait = 1'b1;
                mem_read = 1'b1;
                if (mem_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Line status bits, refill address latch and held read data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_arr  <= '0;
            dirty_arr  <= '0;
            miss_blk   <= '0;
            readdata_q <= '0;
        end else begin
            if (miss_start) miss_blk <= address[7:2];
            if (read_hit)   readdata_q <= sel_byte;
            if (write_hit)  dirty_arr[index] <= 1'b1;
            if (state == FETCH && mem_done) begin
                valid_arr[miss_index] <= 1'b1;
                dirty_arr[miss_index] <= 1'b0;
            end
        end
    end

    // Data and tag arrays: store hits and block refills.
    // NOTE: the arrays carry no reset; valid bits alone decide whether their contents mean anything.
    always_ff @(posedge CLK) begin
        if (write_hit) data_arr[index][{offset, 3'b000} +: 8] <= writedata;
        if (state == FETCH && mem_done) begin
            data_arr[miss_index] <= mem_readdata;
            tag_arr[miss_index]  <= miss_blk[5:3];
        end
    end

`ifdef DCACHE_STATS_EN
    logic after_refill;  // the next IDLE cycle replays an access already counted as a miss

    // Saturating per-access hit/miss counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_count    <= '0;
            miss_count   <= '0;
            after_refill <= 1'b0;
        end else begin
            if (state == FETCH && mem_done) after_refill <= 1'b1;
            else if (state == IDLE)         after_refill <= 1'b0;
            if (state == IDLE && req && !after_refill) begin
                if (hit) begin
                    if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                end else begin
                    if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule
